// File: rtl/mio_bus_resp.sv
// -----------------------------------------------------------------------------
// mio_bus_resp
//   Memory-mapped I/O responder for a simple CPU bus. Each request is latched
//   in IDLE, optionally held for RAM wait states, and completed with a
//   one-cycle MIO_ready strobe in ACK. Writes take effect at the edge that
//   closes the ACK cycle.
//
//   Address map (Addr_in[31:28]):
//     0x0 : RAM, 2^RAM_AW 32-bit words, word index Addr_in[RAM_AW+1:2]
//     0xE : GPIO, read {led_out, sw_in}, write led_out <= Data_in[15:0]
//     0xF : free-running 32-bit counter (only with MIO_COUNTER_EN)
//     else: unmapped, reads 0, writes dropped, addr_err with MIO_ready
//
//   Build option:
//     MIO_COUNTER_EN - when defined, the 0xF region holds a loadable
//                      free-running counter; otherwise 0xF is unmapped.
//
//   Parameters:
//     WAIT_CYCLES - RAM wait states, 0..7
//     RAM_AW      - RAM word-address width, 1..25
//
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-high reset
//     CPU_MIO   in   request valid
//     mem_w     in   1 = write, 0 = read
//     Addr_in   in   byte address (bits [1:0] ignored)
//     Data_in   in   write data
//     sw_in     in   switch inputs
//     Data_out  out  read data, nonzero only while MIO_ready is high
//     MIO_ready out  one-cycle completion strobe
//     addr_err  out  unmapped-access flag, coincident with MIO_ready
//     led_out   out  LED register
// -----------------------------------------------------------------------------
module mio_bus_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [15:0] sw_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        addr_err,
    output logic [15:0] led_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_GPIO = 4'hE;
    localparam logic [3:0] REG_CNT  = 4'hF;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    // Loaded on entry to WAIT; ACK follows the cycle in which it reaches 0.
    localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    function automatic logic is_mapped(input logic [3:0] region);
`ifdef MIO_COUNTER_EN
        return (region == REG_RAM) || (region == REG_GPIO) || (region == REG_CNT);
`else
        return (region == REG_RAM) || (region == REG_GPIO);
`endif
    endfunction

    state_t                state_q;
    logic [2:0]            wait_q;
    logic                  ready_q;
    logic                  err_q;
    logic [15:0]           led_q;

    // Latched transaction
    logic [3:0]            region_q;
    logic [RAM_AW-1:0]     idx_q;
    logic [31:0]           wdata_q;
    logic                  we_q;

    logic [31:0]           mem_q [0:(1 << RAM_AW) - 1];
    logic [31:0]           cnt_rd;
    logic [31:0]           rdata;

    logic                  commit;
    assign commit = (state_q == S_ACK) && we_q;

    // Control FSM with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= 16'h0000;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CPU_MIO) begin
                        if ((Addr_in[31:28] == REG_RAM) && HAS_WAIT) begin
                            state_q <= S_WAIT;
                            wait_q  <= WAIT_LAST;
                        end else begin
                            state_q <= S_ACK;
                            ready_q <= 1'b1;
                            err_q   <= !is_mapped(Addr_in[31:28]);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q <= S_ACK;
                        ready_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    if (commit && (region_q == REG_GPIO)) begin
                        led_q <= wdata_q[15:0];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request capture; later changes on the bus do not disturb the transaction
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && CPU_MIO) begin
            region_q <= Addr_in[31:28];
            idx_q    <= Addr_in[RAM_AW+1:2];
            wdata_q  <= Data_in;
            we_q     <= mem_w;
        end
    end

    // RAM contents survive reset; a reset edge suppresses the pending write
    always_ff @(posedge clk) begin
        if (!rst && commit && (region_q == REG_RAM)) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef MIO_COUNTER_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // A counter write replaces that cycle's increment
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (commit && (region_q == REG_CNT)) begin
            cnt_d = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0000_0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_rd = cnt_q;
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata_q[31:16];
    assign cnt_rd       = 32'h0000_0000;
`endif

    // Read data is formed from the ACK-cycle state so counter and switch
    // values are those present while MIO_ready is high.
    always_comb begin
        rdata = 32'h0000_0000;
        if (!we_q) begin
            case (region_q)
                REG_RAM:  rdata = mem_q[idx_q];
                REG_GPIO: rdata = {led_q, sw_in};
                REG_CNT:  rdata = cnt_rd;
                default:  rdata = 32'h0000_0000;
            endcase
        end
    end

    logic unused_addr;
    assign unused_addr = ^{Addr_in[27:RAM_AW+2], Addr_in[1:0]};

    assign Data_out  = ready_q ? rdata : 32'h0000_0000;
    assign MIO_ready = ready_q;
    assign addr_err  = err_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus_resp.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_resp
//   Directed bench for mio_bus_resp (WAIT_CYCLES=2, RAM_AW=8). Inputs change
//   1 time unit after the rising edge; outputs are sampled at that point, so
//   "cycle N" below is the cycle that starts at the Nth edge after the
//   request is presented. Expected values follow MIO_COUNTER_EN.
// -----------------------------------------------------------------------------
module tb_mio_bus_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [15:0] sw_in;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic        addr_err;
    logic [15:0] led_out;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef MIO_COUNTER_EN
    localparam logic CNT_ERR = 1'b0;
`else
    localparam logic CNT_ERR = 1'b1;
`endif

    mio_bus_resp #(
        .WAIT_CYCLES(2),
        .RAM_AW     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .CPU_MIO  (CPU_MIO),
        .mem_w    (mem_w),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .sw_in    (sw_in),
        .Data_out (Data_out),
        .MIO_ready(MIO_ready),
        .addr_err (addr_err),
        .led_out  (led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the bus after it is sampled, and check
    // latency, read data, error flag and idle-time output cleanliness.
    // Returns in the IDLE cycle after ACK.
    task automatic bus_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input int exp_lat,
                           input logic [31:0] exp_dout, input logic exp_err);
        int          lat   = -1;
        int          stray = 0;
        logic [31:0] dout  = 32'h0;
        logic        err   = 1'b0;
        CPU_MIO = 1'b1;
        mem_w   = we;
        Addr_in = addr;
        Data_in = data;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            step();
            if (c == 1) begin
                CPU_MIO = 1'b0;
                mem_w   = ~we;
                Addr_in = 32'hE000_0000;
                Data_in = 32'hFFFF_FFFF;
            end
            if (MIO_ready) begin
                lat  = c;
                dout = Data_out;
                err  = addr_err;
            end else if (Data_out != 32'h0 || addr_err) begin
                stray++;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dout"}, dout, exp_dout);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_quiet"}, stray, 0);
        step();
        chk({tag, "_pulse"}, {31'b0, MIO_ready}, 32'h0);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            step();
            if (MIO_ready) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic [15:0] pat;
        logic [31:0] held_dout;

        rst     = 1'b1;
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        Addr_in = 32'h0;
        Data_in = 32'h0;
        sw_in   = 16'h0000;

        // Reset state
        step();
        step();
        chk("rst_ready", {31'b0, MIO_ready}, 32'h0);
        chk("rst_dout", Data_out, 32'h0);
        chk("rst_err", {31'b0, addr_err}, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);

        // Reset wins over a simultaneous GPIO write request
        CPU_MIO = 1'b1;
        mem_w   = 1'b1;
        Addr_in = 32'hE000_0000;
        Data_in = 32'h0000_FFFF;
        step();
        rst     = 1'b0;
        CPU_MIO = 1'b0;
        quiet("rst_prio_ready", 3);
        chk("rst_prio_led", {16'h0, led_out}, 32'h0);

        // RAM write/read, wait states, byte-offset bits ignored
        bus_req("ram_wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
        bus_req("ram_rd10", 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        bus_req("ram_rd13", 1'b0, 32'h0000_0013, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        bus_req("ram_wr16", 1'b1, 32'h0000_0016, 32'h0BAD_F00D, 3, 32'h0, 1'b0);
        bus_req("ram_rd14", 1'b0, 32'h0000_0014, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
        bus_req("ram_rd10b", 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        bus_req("ram_wr00", 1'b1, 32'h0000_0000, 32'h0102_0304, 3, 32'h0, 1'b0);

        // GPIO
        bus_req("gpio_wr", 1'b1, 32'hE000_0000, 32'h1234_A5A5, 1, 32'h0, 1'b0);
        chk("gpio_led", {16'h0, led_out}, 32'h0000_A5A5);
        sw_in = 16'h00FF;
        bus_req("gpio_rd", 1'b0, 32'hE000_0000, 32'h0, 1, 32'hA5A5_00FF, 1'b0);

        // Unmapped read and write leave RAM, LEDs and counter alone
        bus_req("unm_rd", 1'b0, 32'h5000_0000, 32'h0, 1, 32'h0, 1'b1);
        bus_req("unm_wr", 1'b1, 32'h7000_0000, 32'h0000_0055, 1, 32'h0, 1'b1);
        chk("unm_led", {16'h0, led_out}, 32'h0000_A5A5);
        bus_req("unm_ram0", 1'b0, 32'h0000_0000, 32'h0, 3, 32'h0102_0304, 1'b0);

        // Counter: load 0xFFFFFFFE, one dead cycle, then read -> wrapped to 0;
        // an immediate second read lands two cycles later -> 2.
        bus_req("cnt_wr", 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 1, 32'h0, CNT_ERR);
        step();
        bus_req("cnt_wrap", 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0, CNT_ERR);
`ifdef MIO_COUNTER_EN
        bus_req("cnt_next", 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0000_0002, 1'b0);
`else
        bus_req("cnt_next", 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0, 1'b1);
`endif

        // Reset during WAIT of a RAM write aborts it
        bus_req("ram_wr40", 1'b1, 32'h0000_0040, 32'hCAFE_0001, 3, 32'h0, 1'b0);
        CPU_MIO = 1'b1;
        mem_w   = 1'b1;
        Addr_in = 32'h0000_0040;
        Data_in = 32'h9999_9999;
        step();
        CPU_MIO = 1'b0;
        rst     = 1'b1;
        chk("abort_c1_ready", {31'b0, MIO_ready}, 32'h0);
        step();
        rst = 1'b0;
        quiet("abort_ready", 5);
        chk("abort_led", {16'h0, led_out}, 32'h0);
        bus_req("abort_ram40", 1'b0, 32'h0000_0040, 32'h0, 3, 32'hCAFE_0001, 1'b0);
        bus_req("abort_ram10", 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // CPU_MIO held high: a new RAM read starts only at the next IDLE
        pat       = 16'h0;
        held_dout = 32'h0;
        CPU_MIO   = 1'b1;
        mem_w     = 1'b0;
        Addr_in   = 32'h0000_0010;
        for (int c = 1; c <= 8; c++) begin
            step();
            pat[c] = MIO_ready;
            if (MIO_ready) held_dout = Data_out;
            if (c == 8) CPU_MIO = 1'b0;
        end
        chk("busy_ram_pat", {16'h0, pat}, 32'h0000_0088);
        chk("busy_ram_dout", held_dout, 32'hDEAD_BEEF);
        quiet("busy_ram_after", 4);

        // Same for single-cycle GPIO reads
        pat     = 16'h0;
        CPU_MIO = 1'b1;
        Addr_in = 32'hE000_0000;
        for (int c = 1; c <= 6; c++) begin
            step();
            pat[c] = MIO_ready;
            if (c == 6) CPU_MIO = 1'b0;
        end
        chk("busy_gpio_pat", {16'h0, pat}, 32'h0000_002A);
        quiet("busy_gpio_after", 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mio_bus_resp.md
MIO_BUS_RESP -- requirements
Module: mio_bus_resp

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: RAM access wait states, legal range 0-7.
REQ-002 SHALL have parameter RAM_AW, default 8: RAM word-address width, giving 2^RAM_AW 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port CPU_MIO, input, 1 bit: bus request valid from the CPU.
REQ-006 SHALL have port mem_w, input, 1 bit: 1 = write request, 0 = read request.
REQ-007 SHALL have port Addr_in, input, 32 bits: byte address.
REQ-008 SHALL have port Data_in, input, 32 bits: write data from the CPU.
REQ-009 SHALL have port sw_in, input, 16 bits: switch inputs.
REQ-010 SHALL have port Data_out, output, 32 bits: read data to the CPU.
REQ-011 SHALL have port MIO_ready, output, 1 bit: one-cycle transaction-complete strobe.
REQ-012 SHALL have port addr_err, output, 1 bit: unmapped-access flag, asserted together with MIO_ready.
REQ-013 SHALL have port led_out, output, 16 bits: LED register.

Function
REQ-014 SHALL decode Addr_in[31:28] as follows:
- 0x0 = RAM, word index Addr_in[RAM_AW+1:2].
- 0xE = GPIO.
- 0xF = counter.
- Any other value = unmapped.
REQ-015 SHALL ignore Addr_in[1:0]; all accesses are full words.
REQ-016 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-017 SHALL, in IDLE with CPU_MIO=1, latch Addr_in, Data_in and mem_w at the clock edge, then move:
- to WAIT if the target is RAM and WAIT_CYCLES>0;
- to ACK otherwise.
REQ-018 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then move to ACK.
REQ-019 SHALL, in ACK, drive MIO_ready=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL give the following latency, with the request sampled in cycle 0:
- MIO_ready high in cycle 1+WAIT_CYCLES for RAM;
- MIO_ready high in cycle 1 for GPIO, counter and unmapped targets.
REQ-021 SHALL accept a new request no earlier than the first IDLE cycle after ACK; CPU_MIO during WAIT or ACK is ignored.
REQ-022 SHALL complete a latched transaction even if CPU_MIO or Addr_in changes mid-transaction.
REQ-023 SHALL drive Data_out with read data only while MIO_ready=1, and 0 at all other times, including for write transactions.
REQ-024 SHALL commit writes at the clock edge that ends the ACK cycle, exactly once per transaction.
REQ-025 SHALL handle RAM reads by returning the word at the latched index; RAM writes store the latched Data_in.
REQ-026 SHALL handle GPIO as follows:
- Read returns {led_out, sw_in}, with led_out in bits [31:16].
- Write loads led_out with Data_in[15:0].
REQ-027 SHALL handle unmapped accesses as follows:
- Read returns 0.
- Write has no effect.
- addr_err=1 in the ACK cycle, 0 otherwise.
REQ-028 SHALL keep a 32-bit counter that increments by 1 every cycle and wraps 0xFFFFFFFF->0x00000000.
REQ-029 SHALL return, for a counter read, the counter value present during the ACK cycle.
REQ-030 SHALL, on a counter write, load the counter with Data_in, overriding that cycle's increment, and resume incrementing from the loaded value.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, set: state=IDLE, MIO_ready=0, Data_out=0, addr_err=0, led_out=0, counter=0.
REQ-032 SHALL abort any in-flight transaction on reset mid-WAIT or mid-ACK: no write is committed and no MIO_ready is issued.
REQ-033 SHALL NOT reset RAM contents.
REQ-034 SHALL let rst take priority over CPU_MIO in the same cycle.

Configuration
REQ-035 SHALL, with macro MIO_COUNTER_EN defined, implement the counter region per REQ-028 to REQ-030.
REQ-036 SHALL, without MIO_COUNTER_EN, omit the counter hardware and treat 0xF region accesses as unmapped per REQ-027.

Verification
REQ-037 SHALL cover RAM write then read, WAIT_CYCLES=2:
- Write 0x00000010 <- 0xDEADBEEF -> MIO_ready in cycle 3.
- Read 0x00000010 -> Data_out=0xDEADBEEF with MIO_ready in cycle 3.
REQ-038 SHALL cover GPIO:
- Write 0xE0000000 <- 0x1234A5A5 -> led_out=0xA5A5.
- Read with sw_in=0x00FF -> Data_out=0xA5A500FF in cycle 1.
REQ-039 SHALL cover counter wrap: write 0xF0000000 <- 0xFFFFFFFE, then read back-to-back -> Data_out=0x00000000 (load+increment+increment across the dead cycle).
REQ-040 SHALL cover unmapped access: read 0x50000000 -> Data_out=0, addr_err=1 and MIO_ready=1 in the same cycle; no RAM, LED or counter change.
REQ-041 SHALL cover reset mid-transaction: RAM write issued, rst=1 in cycle 1 -> no MIO_ready, RAM word unchanged, led_out=0.
REQ-042 SHALL cover a request during busy: CPU_MIO held high through ACK -> second transaction starts at the next IDLE; exactly one MIO_ready per accepted request.
